// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default oversample ratio, line idle level.
// Used by both the transmitter and the receiver side.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int   UART_OVERSAMPLE = 16;
    localparam logic UART_LINE_IDLE  = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts uart_tick pulses and flags the tick that completes OVERSAMPLE.
// Latency: bit_end is combinational on the completing tick; no backpressure, clear holds the count at 0.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic uart_tick,
    output logic bit_end
);

    localparam int              CW   = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]   LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] tick_cnt;

    // Asserted on the very edge that samples the final tick so the owner can act on it.
    assign bit_end = uart_tick && !clear && (tick_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            tick_cnt <= '0;
        end else if (uart_tick) begin
            tick_cnt <= (tick_cnt == LAST) ? '0 : tick_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_BITS LSB first, optional even parity (UART_TX_PARITY_EN), STOP_BITS stop.
// Latency: Tx falls on the accepting edge; each bit lasts OVERSAMPLE uart_tick pulses.
// Backpressure: tx_start is ignored while tx_busy is high; accepted again in the tx_done cycle.
module uart_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 Tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int            BW        = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    uart_state_t          state;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 bit_end;
    logic                 timer_clear;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    // Holding the timer clear in IDLE discards idle ticks and the tick coincident with acceptance.
    assign timer_clear = (state == IDLE);

    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .uart_tick(uart_tick),
        .bit_end  (bit_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            Tx      <= UART_LINE_IDLE;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        shreg   <= tx_data;
                        bit_cnt <= '0;
                        Tx      <= ~UART_LINE_IDLE;
                        tx_busy <= 1'b1;
                        state   <= START;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        Tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            Tx    <= parity_bit;
                            state <= PARITY;
`else
                            Tx    <= UART_LINE_IDLE;
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            Tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        Tx    <= UART_LINE_IDLE;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    // bit_cnt is reused to count stop-bit periods.
                    if (bit_end) begin
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    Tx      <= UART_LINE_IDLE;
                    tx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
